// File: rtl/servant_sleep_pkg.sv
// Shared types for the servant sleep controller: FSM state encoding and wake-cause bit positions.
// Pure declarations: no latency and no backpressure.
package servant_sleep_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } sleep_state_t;

  localparam int CAUSE_IRQ = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_TMR = 2;

  // A down-counter preloaded with n-1 needs enough bits to hold 0..n-1, and never fewer than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servant_clkgate.sv
// Glitch-free clock gate: the enable is latched while clk is low and ANDed with clk.
// Enable changes take effect at the next clk rising edge; there is no backpressure.
module servant_clkgate (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/servant_sleep_ctrl.sv
// Sleep/wake controller: drains the bus, gates the core clock, and wakes on IRQ, SW request or timer.
// Gating happens DRAIN_CYCLES+1 edges after the request and ungating WAKE_CYCLES+1 edges after wake; a pending IRQ refuses sleep.
module servant_sleep_ctrl
  import servant_sleep_pkg::*;
#(
  parameter int N_IRQ        = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int WAKE_CYCLES  = 8,
  parameter int TIMER_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sleep_req,
  input  logic               i_wakeup_req,
  input  logic [N_IRQ-1:0]   i_irq,
  input  logic [N_IRQ-1:0]   i_irq_mask,
  input  logic [TIMER_W-1:0] i_wake_time,
  output logic               o_gclk,
  output logic               o_clk_en,
  output logic               o_sleeping,
  output logic               o_irq_pending,
  output logic [2:0]         o_wake_cause
);

  localparam int CNT_MAX = (DRAIN_CYCLES > WAKE_CYCLES) ? DRAIN_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic                              pend;

  sleep_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               clk_en_q, clk_en_d;
  logic [2:0]         cause_q, cause_d;
  logic               sleeping_q;
  logic               tmr_hit;
  logic               wake_evt;

  // The mask is quasi-static and software-written, so it is applied after the synchroniser unsynchronised.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_irq};
    end
  end

  assign pend = |(sync_q[SYNC_STAGES-1] & i_irq_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      timer_q    <= '0;
      clk_en_q   <= 1'b1;
      cause_q    <= '0;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      clk_en_q   <= clk_en_d;
      cause_q    <= cause_d;
      sleeping_q <= (state_d == ST_SLEEP) || (state_d == ST_WAKE);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    clk_en_d = clk_en_q;
    cause_d  = cause_q;
    // A zero load never reaches 1, so a disabled timer can never fire.
    tmr_hit  = (timer_q == TIMER_W'(1));
    wake_evt = pend | i_wakeup_req | tmr_hit;

    case (state_q)
      ST_RUN: begin
        if (i_sleep_req && !pend) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (pend || i_wakeup_req) begin
          state_d = ST_RUN;
        end else if (cnt_q == '0) begin
          state_d  = ST_SLEEP;
          clk_en_d = 1'b0;
          cause_d  = '0;
          timer_d  = i_wake_time;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SLEEP: begin
        if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
        if (wake_evt) begin
          state_d            = ST_WAKE;
          cnt_d              = CNT_W'(WAKE_CYCLES - 1);
          cause_d[CAUSE_IRQ] = pend;
          cause_d[CAUSE_SW]  = i_wakeup_req;
          cause_d[CAUSE_TMR] = tmr_hit;
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d  = ST_RUN;
          clk_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign o_clk_en      = clk_en_q;
  assign o_sleeping    = sleeping_q;
  assign o_irq_pending = pend;
  assign o_wake_cause  = cause_q;

  servant_clkgate u_clkgate (
    .clk  (i_clk),
    .en   (clk_en_q),
    .gclk (o_gclk)
  );

endmodule
